// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decoder
// handshake and execute redirect, grouped for fetch_unit.
interface fetch_unit_if;
  logic        IMEM_EN;
  logic [10:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IR;
  logic [10:0] PC;
  logic        VALID;
  logic        STALL;
  logic        HALT;
  logic        REDIR_VALID;
  logic [10:0] REDIR_PC;
  logic        FETCH_IDLE;

  modport master (
    output IMEM_EN,
    output IMEM_ADDR,
    input  IMEM_RDATA,
    output IR,
    output PC,
    output VALID,
    input  STALL,
    input  HALT,
    input  REDIR_VALID,
    input  REDIR_PC,
    output FETCH_IDLE
  );

  modport slave (
    input  IMEM_EN,
    input  IMEM_ADDR,
    output IMEM_RDATA,
    input  IR,
    input  PC,
    input  VALID,
    output STALL,
    output HALT,
    output REDIR_VALID,
    output REDIR_PC,
    input  FETCH_IDLE
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential issue to a synchronous
// imem, small return queue, flush on HALT, redirect from execute.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input logic         CLK,
  input logic         N_RST,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, WAIT} state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [10:0] pc;
  } entry_t;

  state_t        state_q, state_d;
  logic [10:0]   fpc_q, fpc_d;
  logic [10:0]   iaddr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic          inflight_q;
  logic          kill_q, kill_d;
  entry_t        fifo_q [DEPTH];

  logic          live;
  logic          consume;
  logic          flush;
  logic          clear;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  entry_t        head;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    live    = (cnt_q != '0) && (state_q == RUN);
    consume = live && !bus.STALL;
    flush   = consume && bus.HALT;
    clear   = flush || bus.REDIR_VALID;
    // occupancy the queue will reach once the in-flight read lands
    occ     = {1'b0, cnt_q}
            + (CW+1)'(inflight_q)
            - (CW+1)'(consume);
    issue   = N_RST
            && (state_q == RUN)
            && !flush
            && !bus.REDIR_VALID
            && (occ < (CW+1)'(DEPTH));
    push    = inflight_q && !kill_q && !clear;
    pop     = consume && !clear;
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rd_d    = pop  ? nxt(rd_q) : rd_q;
    wr_d    = push ? nxt(wr_q) : wr_q;
    kill_d  = clear && issue;
    if (issue) begin
      fpc_d = fpc_q + 11'd1;
    end
    unique case (1'b1)
      bus.REDIR_VALID: begin
        fpc_d   = bus.REDIR_PC;
        state_d = RUN;
        cnt_d   = '0;
        rd_d    = '0;
        wr_d    = '0;
      end
      flush && !bus.REDIR_VALID: begin
        state_d = WAIT;
        cnt_d   = '0;
        rd_d    = '0;
        wr_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q    <= RUN;
      fpc_q      <= RESET_PC;
      iaddr_q    <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inflight_q <= issue;
      kill_q     <= kill_d;
      if (issue) begin
        iaddr_q <= fpc_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_q] <= '{ir: bus.IMEM_RDATA, pc: iaddr_q};
    end
  end

  assign head           = fifo_q[rd_q];
  assign bus.IMEM_EN    = issue;
  assign bus.IMEM_ADDR  = fpc_q;
  assign bus.VALID      = live;
  assign bus.IR         = live ? head.ir : '0;
  assign bus.PC         = live ? head.pc : '0;
  assign bus.FETCH_IDLE = (state_q == WAIT);

  a_no_overflow: assert property (
    @(posedge CLK) disable iff (!N_RST)
    !(push && (cnt_q == CW'(DEPTH)) && !consume)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Drives the synchronous instruction memory and buffers returned words in a small queue.
- Presents IR, PC and VALID to the decoder and honours its STALL and HALT outputs.
- On a consumed control transfer (HALT), flushes younger work and waits for a redirect from execute.

Parameters:
- DEPTH, 2, fetch-queue entries (≥2).
- RESET_PC, 11'd0, first fetch address after reset.

Ports:
- CLK  in  1  clock.
- N_RST  in  1  reset, asynchronous, active-low.
- IMEM_EN  out  1  read strobe; data is returned on the next cycle.
- IMEM_ADDR  out  11  word address of the read.
- IMEM_RDATA  in  32  read data, valid the cycle after IMEM_EN.
- IR  out  32  head instruction word to the decoder.
- PC  out  11  address of IR.
- VALID  out  1  IR/PC hold a live instruction.
- STALL  in  1  decoder cannot accept IR this cycle.
- HALT  in  1  decoder took a control-transfer/HLT, or is stopped.
- REDIR_VALID  in  1  one-cycle redirect pulse from execute.
- REDIR_PC  in  11  redirect target (taken target or fall-through).
- FETCH_IDLE  out  1  high in state WAIT.

Behaviour:
- Reset (asynchronous, N_RST low):
  - fpc=RESET_PC, state=RUN, queue count=0, inflight=0.
  - IMEM_EN=0, VALID=0, IR=0, PC=0, FETCH_IDLE=0.
- States:
  - RUN: issue sequential fetches.
  - WAIT: no issue; wait for REDIR_VALID.
- Signal definitions:
  - consume = VALID & ~STALL.
  - flush = consume & HALT.
  - inflight = registered IMEM_EN of the previous cycle.
  - kill = registered flag marking that in-flight read as discarded.
- Issue (combinational, from fpc and queue state):
  - Condition: state==RUN & ~flush & ~REDIR_VALID & (count + inflight − consume) < DEPTH.
  - IMEM_EN=issue, IMEM_ADDR=fpc.
  - On issue: fpc <= fpc+1, modulo 2048 (2047 wraps to 0).
  - Sustains 1 instruction/cycle when the decoder never stalls.
- Return: when inflight & ~kill, {IMEM_RDATA, issued address} is pushed to the queue tail that cycle.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by the issue rule. Assertion: a push while count==DEPTH & ~consume is an error.
- Outputs:
  - VALID = (count≠0) & state==RUN.
  - IR/PC = head entry when VALID, else 0.
  - Latency: IMEM_EN at cycle t gives VALID at t+2 if the queue was empty.
- STALL: head is held; IR/PC/VALID stable until consumed.
- HALT behaviour:
  - HALT with VALID=0, or with STALL=1, has no effect (decoder STOP case handled by WAIT).
  - flush: pop head, clear queue (count=0), set kill for any read in flight, suppress issue, state→WAIT.
  - FETCH_IDLE=1 from the next cycle.
- Redirect:
  - REDIR_VALID in WAIT: fpc<=REDIR_PC, state→RUN; first issue is the following cycle.
  - REDIR_VALID in RUN: same effect plus queue clear and kill of the in-flight read.
  - REDIR_VALID and flush in the same cycle: the redirect wins (state RUN, fpc=REDIR_PC, queue cleared).
- HLT: the decoder consumes HLT with HALT=1, so fetch goes to WAIT. No redirect arrives, so the block stays idle until reset.
- Reset mid-operation: all state cleared immediately; in-flight return is ignored because inflight=0.

Test Plan:
- Memory model mem[a]=32'hA000_0000|a; reset release, STALL=0, HALT=0 → IMEM_EN=1 at cycles 0..N; VALID first high at cycle 2 with IR=32'hA000_0000, PC=0; then PC 1,2,3 on consecutive cycles.
- STALL held high for 3 cycles while PC=5 → IR/PC frozen at 5 for 3 cycles; IMEM_EN drops once count+inflight reaches 2; after release PC=6,7 follow with no gap or duplicate.
- HALT with VALID, ~STALL at PC=8 → next cycle VALID=0, FETCH_IDLE=1, the returning word for PC 9 is dropped; REDIR_VALID with REDIR_PC=11'd40 two cycles later → IMEM_ADDR=40 the following cycle, VALID with PC=40 two cycles after that.
- Wrap: RESET_PC=11'd2046 → PC sequence 2046, 2047, 0, 1.
- Simultaneous flush and REDIR_VALID (REDIR_PC=11'd100) → no WAIT entry (FETCH_IDLE stays 0), next VALID instruction has PC=100.
- HLT consumed, HALT then held high continuously with no redirect for 20 cycles → IMEM_EN=0 and VALID=0 throughout; async N_RST pulse → fetch restarts at RESET_PC.
